// File: rtl/sample_accumulator_if.sv
// Result channel of sample_accumulator: conversion result, valid/ready handshake
// and the sticky overrun flag.
interface sample_accumulator_if #(
  parameter int ACC_W = 5
);
  // valid_o/ready_i: a result transfers on every rising edge where valid_o && ready_i.
  // The producer holds result_o stable while valid_o=1 and never waits on ready_i.
  // A newer result may replace an unconsumed one; overrun_o records that.
  logic [ACC_W-1:0] result_o;
  logic             valid_o;
  logic             ready_i;
  logic             overrun_o;

  modport master (
    output result_o,
    output valid_o,
    output overrun_o,
    input  ready_i
  );

  modport slave (
    input  result_o,
    input  valid_o,
    input  overrun_o,
    output ready_i
  );
endinterface

// File: rtl/sample_accumulator.sv
// Counts comparator ones over each window delimited by the cycle counter's stop pulse.
// Optional macro COMPARATOR_SYNC_EN adds a 2-flop synchronizer on comparator_i.
module sample_accumulator #(
  parameter int WINDOW_LEN = 24,
  parameter int ACC_W      = $clog2(WINDOW_LEN + 1)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                enable_i,
  input  logic                comparator_i,
  input  logic                stop_i,
  output logic                increment_o,
  output logic [1:0]          dbg_state_o,
  sample_accumulator_if.master res_if
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_result;
  logic             r_valid;
  logic             r_overrun;
  logic             w_sample;

`ifdef COMPARATOR_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= comparator_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = comparator_i;
`endif

  // The counter must see increment in the same cycle, so this stays combinational.
  assign increment_o = ((r_state == ST_RUN) || (r_state == ST_FLUSH)) && !stop_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_valid && res_if.ready_i) begin
        r_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable_i) begin
            r_state   <= ST_RUN;
            r_acc     <= '0;
            r_overrun <= 1'b0;
          end
        end
        ST_RUN: begin
          if (stop_i) begin
            // Publishing wins over the handshake clear above, so a coincident accept keeps valid high.
            r_result <= r_acc;
            r_valid  <= 1'b1;
            r_acc    <= '0;
            if (r_valid && !res_if.ready_i) begin
              r_overrun <= 1'b1;
            end
            r_state <= enable_i ? ST_RUN : ST_IDLE;
          end else if (!enable_i) begin
            r_state <= ST_FLUSH;
            r_acc   <= '0;
          end else begin
            r_acc <= r_acc + {{(ACC_W-1){1'b0}}, w_sample};
          end
        end
        ST_FLUSH: begin
          // Keep the counter running to its stop so both sides land at count 0.
          if (stop_i) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign res_if.result_o  = r_result;
  assign res_if.valid_o   = r_valid;
  assign res_if.overrun_o = r_overrun;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_sample_accumulator.sv
// Bench for sample_accumulator with an attached cycle-counter model and an
// expected-result queue; covers table windows, abort, backpressure and reset.
module tb_sample_accumulator;

  localparam int ACC_W = 5;
`ifdef COMPARATOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int PAD = 2 - LAT;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       enable_i;
  logic       comparator_i;
  logic       stop_i;
  logic       increment_o;
  logic [1:0] dbg_state;

  sample_accumulator_if #(.ACC_W(ACC_W)) res_if();

  sample_accumulator dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .enable_i     (enable_i),
    .comparator_i (comparator_i),
    .stop_i       (stop_i),
    .increment_o  (increment_o),
    .dbg_state_o  (dbg_state),
    .res_if       (res_if.master)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // cycle counter model: stop at terminal count 24, then back to 0
  logic [4:0] cnt;
  assign stop_i = (cnt == 5'd24);
  always @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)            cnt <= 5'd0;
    else if (stop_i)         cnt <= 5'd0;
    else if (increment_o)    cnt <= cnt + 5'd1;
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // scoreboard
  logic [ACC_W-1:0] exp_q[$];
  bit               comp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  bit               mon_en   = 1'b0;
  int               last_acc = -1;
  logic [ACC_W-1:0] mon_exp;

  typedef struct {
    logic [23:0]      pattern;
    logic [ACC_W-1:0] exp_res;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_n_i && mon_en && res_if.valid_o && res_if.ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0d expected no result", res_if.result_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("table_result", int'(res_if.result_o), int'(mon_exp));
      end
      if (last_acc >= 0) check("result_interval", cyc - last_acc, 25);
      last_acc = cyc;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
    if (comp_q.size() > 0) comparator_i = comp_q.pop_front();
    else                   comparator_i = 1'b0;
  endtask

  task automatic push_pad();
    for (int i = 0; i < PAD; i++) comp_q.push_back(1'b0);
  endtask

  task automatic push_window(input logic [23:0] p);
    for (int i = 0; i < 24; i++) comp_q.push_back(p[i]);
    comp_q.push_back(1'b0);
  endtask

  task automatic start_run();
    step();
    step();
    enable_i = 1'b1;
  endtask

  task automatic wait_stop(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (stop_i) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({name, "_stop_seen"}, int'(ok), 1);
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (dbg_state == S_IDLE) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({name, "_idle"}, int'(ok), 1);
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      n++;
      if (res_if.valid_o) break;
    end
  endtask

  initial begin
    int n;
    int n_inc;
    bit saw_valid;
    bit ok;

    vecs[0] = '{24'hFFFFFF, 5'd24};
    vecs[1] = '{24'h555555, 5'd12};
    vecs[2] = '{24'h000000, 5'd0};
    vecs[3] = '{24'h00001F, 5'd5};
    vecs[4] = '{24'h0001FF, 5'd9};
    vecs[5] = '{24'hF0F0F0, 5'd12};
    vecs[6] = '{24'h800001, 5'd2};
    vecs[7] = '{24'h123456, 5'd9};
    vecs[8] = '{24'hFFFFFE, 5'd23};

    rst_n_i         = 1'b0;
    enable_i        = 1'b0;
    comparator_i    = 1'b0;
    res_if.ready_i  = 1'b0;

    #12;
    check("reset_state",   int'(dbg_state), int'(S_IDLE));
    check("reset_inc",     int'(increment_o), 0);
    check("reset_valid",   int'(res_if.valid_o), 0);
    check("reset_result",  int'(res_if.result_o), 0);
    check("reset_overrun", int'(res_if.overrun_o), 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    step();
    step();

    // table windows, continuous run, ready held high
    res_if.ready_i = 1'b1;
    push_pad();
    foreach (vecs[k]) begin
      push_window(vecs[k].pattern);
      exp_q.push_back(vecs[k].exp_res);
    end
    last_acc = -1;
    mon_en   = 1'b1;
    start_run();
    for (int i = 0; i < 9 * 25 + 60 && exp_q.size() > 0; i++) step();
    check("table_drain", exp_q.size(), 0);
    check("table_overrun", int'(res_if.overrun_o), 0);
    enable_i = 1'b0;
    wait_idle("table_end");
    check("table_end_cnt", int'(cnt), 0);

    // abort at count 10
    comp_q.delete();
    push_pad();
    push_window(24'hFFFFFF);
    push_window(24'hFFFFFF);
    start_run();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cnt == 5'd10) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("abort_reach_10", int'(ok), 1);
    enable_i  = 1'b0;
    n_inc     = increment_o ? 1 : 0;
    saw_valid = res_if.valid_o;
    step();
    check("abort_flush_state", int'(dbg_state), int'(S_FLUSH));
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (stop_i) begin
        ok = 1'b1;
        break;
      end
      if (increment_o) n_inc++;
      if (res_if.valid_o) saw_valid = 1'b1;
      step();
    end
    check("abort_stop_seen", int'(ok), 1);
    check("abort_inc_at_stop", int'(increment_o), 0);
    step();
    check("abort_inc_count", n_inc, 14);
    check("abort_no_valid", int'(saw_valid | res_if.valid_o), 0);
    check("abort_idle", int'(dbg_state), int'(S_IDLE));
    check("abort_cnt_zero", int'(cnt), 0);
    mon_en = 1'b0;

    // first-result latency
    comp_q.delete();
    push_pad();
    push_window(24'h00001F);
    start_run();
    wait_valid("latency", n);
    check("first_latency", n, 26);
    check("first_result", int'(res_if.result_o), 5);
    enable_i = 1'b0;
    wait_idle("latency");

    // backpressure over two windows
    res_if.ready_i = 1'b0;
    comp_q.delete();
    push_pad();
    push_window(24'h00001F);
    push_window(24'h0001FF);
    start_run();
    wait_stop("bp_w1");
    step();
    check("bp_w1_valid",   int'(res_if.valid_o), 1);
    check("bp_w1_result",  int'(res_if.result_o), 5);
    check("bp_w1_overrun", int'(res_if.overrun_o), 0);
    wait_stop("bp_w2");
    enable_i = 1'b0;
    step();
    check("bp_w2_result",  int'(res_if.result_o), 9);
    check("bp_w2_valid",   int'(res_if.valid_o), 1);
    check("bp_w2_overrun", int'(res_if.overrun_o), 1);
    check("bp_w2_idle",    int'(dbg_state), int'(S_IDLE));
    enable_i = 1'b1;
    step();
    check("bp_rerun_state",   int'(dbg_state), int'(S_RUN));
    check("bp_rerun_overrun", int'(res_if.overrun_o), 0);
    check("bp_rerun_hold",    int'(res_if.result_o), 9);

    // accept coincident with a new result
    wait_stop("coinc");
    res_if.ready_i = 1'b1;
    enable_i       = 1'b0;
    step();
    check("coinc_valid",   int'(res_if.valid_o), 1);
    check("coinc_result",  int'(res_if.result_o), 0);
    check("coinc_overrun", int'(res_if.overrun_o), 0);
    step();
    check("coinc_consumed", int'(res_if.valid_o), 0);
    wait_idle("coinc");

    // reset mid-window at count 17
    res_if.ready_i = 1'b0;
    comp_q.delete();
    push_pad();
    push_window(24'hFFFFFF);
    push_window(24'hFFFFFF);
    start_run();
    wait_stop("rst_w1");
    step();
    check("rst_pre_result", int'(res_if.result_o), 24);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cnt == 5'd17) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("rst_reach_17", int'(ok), 1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("rst_async_state",   int'(dbg_state), int'(S_IDLE));
    check("rst_async_inc",     int'(increment_o), 0);
    check("rst_async_valid",   int'(res_if.valid_o), 0);
    check("rst_async_result",  int'(res_if.result_o), 0);
    check("rst_async_overrun", int'(res_if.overrun_o), 0);
    check("rst_async_cnt",     int'(cnt), 0);
    enable_i = 1'b0;
    comp_q.delete();
    @(negedge clk_i);
    rst_n_i = 1'b1;
    res_if.ready_i = 1'b1;
    push_pad();
    push_window(24'h123456);
    start_run();
    wait_valid("rst_fresh", n);
    check("rst_fresh_latency", n, 26);
    check("rst_fresh_result", int'(res_if.result_o), 9);
    enable_i = 1'b0;
    wait_idle("rst_fresh");

    // ones only at counts 22,23: counted directly, shifted out with the synchronizer
    comp_q.delete();
    enable_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      comparator_i = (cnt == 5'd22) || (cnt == 5'd23);
      if (stop_i) begin
        enable_i = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    check("shift_stop_seen", int'(ok), 1);
    step();
    check("shift_valid", int'(res_if.valid_o), 1);
    check("shift_result", int'(res_if.result_o), (LAT == 0) ? 2 : 0);
    check("shift_idle", int'(dbg_state), int'(S_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
